regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file for the pipelined core, successor to the single-write/dual-read register file. It adds configurable width, depth and port counts, a same-cycle write-to-read bypass, a per-register pending-write scoreboard for hazard detection, and a multi-cycle soft-clear sequencer. It sits between the decode stage (reads, allocation) and the writeback stage (writes).

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 32, register count (power of 2, ≥ 2); AW = $clog2(NUM_REGS)
- NUM_RD, 2, read ports
- NUM_WR, 2, write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to reads
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy
- i_clk  in  1  clock, all state on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_rs_addr  in  [NUM_RD][AW]  read addresses
- o_rs_data  out  [NUM_RD][DATA_W]  read data, combinational
- o_rs_busy  out  [NUM_RD]  addressed register has a pending write
- i_rd_addr  in  [NUM_WR][AW]  write addresses
- i_rd_data  in  [NUM_WR][DATA_W]  write data
- i_rd_wren  in  [NUM_WR]  write enables
- i_alloc_en  in  1  mark i_alloc_addr as pending write
- i_alloc_addr  in  AW  register to mark busy
- i_clr_req  in  1  start soft clear (single-cycle pulse)
- o_clr_busy  out  1  soft clear in progress

## Operation
- Reset (i_reset_n low, asynchronous): all registers 0, all busy bits 0, FSM IDLE, sweep counter 0; o_clr_busy = 0, o_rs_busy = 0, o_rs_data = 0.
- Write: on edge, each port with i_rd_wren=1 updates its register. Same address on several ports: highest-index port wins. Address 0 dropped when ZERO_REG=1.
- Read: o_rs_data[k] = register[i_rs_addr[k]]; 0 if ZERO_REG and address 0.
- Bypass (BYPASS=1, FSM IDLE): if any enabled write port matches i_rs_addr[k] (nonzero when ZERO_REG), o_rs_data[k] = that port's data, highest-index matching port wins. BYPASS=0: old value until after the edge.
- Scoreboard: i_alloc_en sets busy[i_alloc_addr] at the edge; a write to an address clears its busy bit at the edge. Alloc and write to the same address in one cycle: busy stays set (alloc is the newer producer). o_rs_busy[k] = busy[i_rs_addr[k]], not bypassed (a write this cycle still shows busy until the edge). Allocation of address 0 ignored when ZERO_REG=1.
- Soft-clear FSM, states IDLE and CLEAR:
  - IDLE→CLEAR on i_clr_req; all busy bits cleared at that edge; counter = 0.
  - CLEAR: register[counter] ← 0 each cycle, counter increments; CLEAR→IDLE on the edge that clears NUM_REGS-1.
  - In CLEAR: writes, allocations, bypass and further i_clr_req ignored; reads return current contents (partially cleared); o_rs_busy = 0.
  - i_clr_req in the same cycle as writes or allocations: request wins, the others are dropped.
- Asynchronous reset mid-clear: immediate return to IDLE with full reset state.

## Timing
- Read and bypass latency 0 (combinational); write visible through storage 1 cycle later.
- Busy set/clear visible in the cycle after the triggering edge.
- o_clr_busy high for exactly NUM_REGS cycles, starting the cycle after i_clr_req is sampled.
- Reset value of every output: 0.

## Structure
- Shared package regfile_pkg: clr_state_e {IDLE, CLEAR}, the AW helper and default parameter constants.
- Sub-module regfile_scoreboard: busy bit-vector, alloc/write-clear priority, read-port busy lookup and bulk clear. Storage, bypass and the FSM live in regfile_mp.

## Test plan
- Reset then write 32'hDEADBEEF to x5 on port 0; next cycle read x5 on both ports → 32'hDEADBEEF on both; x0 write of 32'h1 → x0 reads 0.
- Same cycle: port 0 writes x7=32'h11, port 1 writes x7=32'h22, read x7 → bypass shows 32'h22, storage holds 32'h22 afterwards; with BYPASS=0 read shows the old value 0 that cycle.
- Allocate x3 → o_rs_busy=1 next cycle; write x3 together with a new allocation of x3 → busy stays 1; write x3 alone → busy 0 next cycle.
- Fill x1..x31 with nonzero values, pulse i_clr_req with a simultaneous write of x9 → write dropped; o_clr_busy high for 32 cycles; all registers read 0 afterwards; i_rd_wren during CLEAR has no effect.
- Pull i_reset_n low at cycle 10 of a clear sweep → o_clr_busy drops immediately, all reads 0, busy bits 0, and a new clear request after release runs the full 32 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_NUM_REGS = 32;
    localparam int unsigned DEF_NUM_RD   = 2;
    localparam int unsigned DEF_NUM_WR   = 2;

    typedef logic [0:0] clr_state_e;
    localparam clr_state_e IDLE  = 1'b0;
    localparam clr_state_e CLEAR = 1'b1;

    // Address width for a register count, never below one bit.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register with alloc/write/bulk-clear update.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned NUM_RD   = DEF_NUM_RD,
    parameter int unsigned NUM_WR   = DEF_NUM_WR,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = addr_w(NUM_REGS)
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic [NUM_WR-1:0][AW-1:0]    i_wr_addr,
    input  logic [NUM_WR-1:0]            i_wr_en,
    input  logic                         i_alloc_en,
    input  logic [AW-1:0]                i_alloc_addr,
    input  logic                         i_bulk_clr,
    input  logic [NUM_RD-1:0][AW-1:0]    i_rs_addr,
    output logic [NUM_RD-1:0]            o_rs_busy_c
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Writes retire first so a same-cycle allocation (newer producer) keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < int'(NUM_WR); w++) begin
            if (i_wr_en[w]) busy_d[i_wr_addr[w]] = 1'b0;
        end
        if (i_alloc_en && !(ZERO_REG && (i_alloc_addr == '0))) begin
            busy_d[i_alloc_addr] = 1'b1;
        end
        if (i_bulk_clr) busy_d = '0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) busy_q <= '0;
        else            busy_q <= busy_d;
    end

    always_comb begin
        o_rs_busy_c = '0;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            o_rs_busy_c[k] = busy_q[i_rs_addr[k]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, hazard scoreboard and soft-clear sweep.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned NUM_RD   = DEF_NUM_RD,
    parameter int unsigned NUM_WR   = DEF_NUM_WR,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = addr_w(NUM_REGS)
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic [NUM_RD-1:0][AW-1:0]      i_rs_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0]  o_rs_data,
    output logic [NUM_RD-1:0]              o_rs_busy,
    input  logic [NUM_WR-1:0][AW-1:0]      i_rd_addr,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  i_rd_data,
    input  logic [NUM_WR-1:0]              i_rd_wren,
    input  logic                           i_alloc_en,
    input  logic [AW-1:0]                  i_alloc_addr,
    input  logic                           i_clr_req,
    output logic                           o_clr_busy
);

    clr_state_e                          state_q;
    clr_state_e                          state_d;
    logic [AW-1:0]                       cnt_q;
    logic [AW-1:0]                       cnt_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]     mem_q;
    logic                                accept;
    logic                                alloc_ok;
    logic                                bulk_clr;
    logic [NUM_WR-1:0]                   wr_ok;
    logic [NUM_RD-1:0]                   busy_c;

    // A clear request in IDLE takes priority over any same-cycle write or allocation.
    always_comb begin
        accept   = (state_q == IDLE) && !i_clr_req;
        bulk_clr = (state_q == IDLE) && i_clr_req;
        alloc_ok = i_alloc_en && accept;
        wr_ok    = '0;
        for (int w = 0; w < int'(NUM_WR); w++) begin
            wr_ok[w] = i_rd_wren[w] && accept && !(ZERO_REG && (i_rd_addr[w] == '0));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (i_clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(NUM_REGS - 1)) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage: sweep clears one entry per cycle; otherwise later write ports override earlier ones.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mem_q <= '0;
        end else if (state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else begin
            for (int w = 0; w < int'(NUM_WR); w++) begin
                if (wr_ok[w]) mem_q[i_rd_addr[w]] <= i_rd_data[w];
            end
        end
    end

    always_comb begin
        o_rs_data = '0;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            o_rs_data[k] = mem_q[i_rs_addr[k]];
            if (ZERO_REG && (i_rs_addr[k] == '0)) o_rs_data[k] = '0;
            if (BYPASS && (state_q == IDLE)) begin
                for (int w = 0; w < int'(NUM_WR); w++) begin
                    if (wr_ok[w] && (i_rd_addr[w] == i_rs_addr[k])) o_rs_data[k] = i_rd_data[w];
                end
            end
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_wr_addr    (i_rd_addr),
        .i_wr_en      (wr_ok),
        .i_alloc_en   (alloc_ok),
        .i_alloc_addr (i_alloc_addr),
        .i_bulk_clr   (bulk_clr),
        .i_rs_addr    (i_rs_addr),
        .o_rs_busy_c  (busy_c)
    );

    always_comb begin
        o_rs_busy  = (state_q == IDLE) ? busy_c : '0;
        o_clr_busy = (state_q == CLEAR);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed vector bench for regfile_mp (bypassing instance plus a non-bypassing twin).
module tb_regfile_mp;

    logic              clk;
    logic              rst_n;
    logic [1:0][4:0]   rs_addr;
    logic [1:0][31:0]  rs_data;
    logic [1:0]        rs_busy;
    logic [1:0][31:0]  nb_rs_data;
    logic [1:0]        nb_rs_busy;
    logic [1:0][4:0]   rd_addr;
    logic [1:0][31:0]  rd_data;
    logic [1:0]        rd_wren;
    logic              alloc_en;
    logic [4:0]        alloc_addr;
    logic              clr_req;
    logic              clr_busy;
    logic              nb_clr_busy;

    int total_cnt = 0;
    int pass_cnt  = 0;

    regfile_mp u_dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_rs_addr    (rs_addr),
        .o_rs_data    (rs_data),
        .o_rs_busy    (rs_busy),
        .i_rd_addr    (rd_addr),
        .i_rd_data    (rd_data),
        .i_rd_wren    (rd_wren),
        .i_alloc_en   (alloc_en),
        .i_alloc_addr (alloc_addr),
        .i_clr_req    (clr_req),
        .o_clr_busy   (clr_busy)
    );

    regfile_mp #(.BYPASS(1'b0)) u_dut_nb (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_rs_addr    (rs_addr),
        .o_rs_data    (nb_rs_data),
        .o_rs_busy    (nb_rs_busy),
        .i_rd_addr    (rd_addr),
        .i_rd_data    (rd_data),
        .i_rd_wren    (rd_wren),
        .i_alloc_en   (alloc_en),
        .i_alloc_addr (alloc_addr),
        .i_clr_req    (clr_req),
        .o_clr_busy   (nb_clr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        al;
        logic [4:0]  aa;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        logic        e_b0;
        logic        e_b1;
        logic [31:0] e_nb0;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        rd_wren    = '0;
        rd_addr    = '0;
        rd_data    = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        clr_req    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n;

    initial begin
        vecs[0]  = '{5'd0, 5'd5, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 32'h0};
        vecs[1]  = '{5'd5, 5'd5, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'h0};
        vecs[2]  = '{5'd5, 5'd5, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF};
        vecs[3]  = '{5'd0, 5'd0, 1, 5'd0, 32'h1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 32'h0};
        vecs[4]  = '{5'd0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 32'h0};
        vecs[5]  = '{5'd7, 5'd5, 1, 5'd7, 32'h11, 1, 5'd7, 32'h22, 0, 5'd0, 32'h22, 32'hDEADBEEF, 0, 0, 32'h0};
        vecs[6]  = '{5'd7, 5'd7, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h22, 32'h22, 0, 0, 32'h22};
        vecs[7]  = '{5'd3, 5'd7, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd3, 32'h0, 32'h22, 0, 0, 32'h0};
        vecs[8]  = '{5'd3, 5'd3, 1, 5'd3, 32'h33, 0, 5'd0, 32'h0, 1, 5'd3, 32'h33, 32'h33, 1, 1, 32'h0};
        vecs[9]  = '{5'd3, 5'd7, 0, 5'd0, 32'h0, 1, 5'd3, 32'h44, 0, 5'd0, 32'h44, 32'h22, 1, 0, 32'h33};
        vecs[10] = '{5'd3, 5'd3, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h44, 32'h44, 0, 0, 32'h44};
        vecs[11] = '{5'd0, 5'd3, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h0, 32'h44, 0, 0, 32'h0};
        vecs[12] = '{5'd0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 32'h0};
        vecs[13] = '{5'd11, 5'd10, 1, 5'd10, 32'h10A, 1, 5'd11, 32'h10B, 0, 5'd0, 32'h10B, 32'h10A, 0, 0, 32'h0};
        vecs[14] = '{5'd11, 5'd10, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h10B, 32'h10A, 0, 0, 32'h10B};

        idle_inputs();
        rs_addr = '0;
        rst_n   = 1'b0;
        #12;
        chk("reset_clr_busy", 32'(clr_busy), 32'h0);
        chk("reset_busy", 32'(rs_busy), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single-cycle vectors: outputs checked combinationally before the edge.
        for (int i = 0; i < NV; i++) begin
            rs_addr[0] = vecs[i].rs0;
            rs_addr[1] = vecs[i].rs1;
            rd_wren    = {vecs[i].we1, vecs[i].we0};
            rd_addr[0] = vecs[i].wa0;
            rd_data[0] = vecs[i].wd0;
            rd_addr[1] = vecs[i].wa1;
            rd_data[1] = vecs[i].wd1;
            alloc_en   = vecs[i].al;
            alloc_addr = vecs[i].aa;
            #2;
            chk($sformatf("v%0d_rs_data0", i), rs_data[0], vecs[i].e_d0);
            chk($sformatf("v%0d_rs_data1", i), rs_data[1], vecs[i].e_d1);
            chk($sformatf("v%0d_rs_busy0", i), 32'(rs_busy[0]), 32'(vecs[i].e_b0));
            chk($sformatf("v%0d_rs_busy1", i), 32'(rs_busy[1]), 32'(vecs[i].e_b1));
            chk($sformatf("v%0d_nobypass0", i), nb_rs_data[0], vecs[i].e_nb0);
            @(posedge clk);
            #1;
        end
        idle_inputs();

        // Fill x1..x31 with 0x100+i, allocating x4 along the way.
        for (int r = 1; r < 32; r += 2) begin
            rd_wren    = 2'b01;
            rd_addr[0] = 5'(r);
            rd_data[0] = 32'h100 + 32'(r);
            if (r + 1 < 32) begin
                rd_wren[1] = 1'b1;
                rd_addr[1] = 5'(r + 1);
                rd_data[1] = 32'h100 + 32'(r + 1);
            end
            alloc_en   = (r == 3);
            alloc_addr = 5'd4;
            tick();
        end
        idle_inputs();
        rs_addr[0] = 5'd4;
        rs_addr[1] = 5'd31;
        #1;
        chk("fill_busy_x4", 32'(rs_busy[0]), 32'h1);
        chk("fill_x31", rs_data[1], 32'h11F);
        tick();

        // Clear request with a colliding write and allocation: both dropped.
        clr_req    = 1'b1;
        rd_wren    = 2'b01;
        rd_addr[0] = 5'd9;
        rd_data[0] = 32'hBAD;
        alloc_en   = 1'b1;
        alloc_addr = 5'd6;
        rs_addr[0] = 5'd9;
        rs_addr[1] = 5'd9;
        #1;
        chk("clr_req_no_bypass", rs_data[0], 32'h109);
        tick();
        clr_req    = 1'b0;
        rd_addr[0] = 5'd1;
        rd_data[0] = 32'hFFFF;
        alloc_addr = 5'd1;
        rs_addr[0] = 5'd5;
        rs_addr[1] = 5'd1;
        n = 0;
        while (clr_busy && n < 100) begin
            if (n == 5) begin
                chk("mid_clear_x5_old", rs_data[0], 32'h105);
                chk("mid_clear_x1_cleared", rs_data[1], 32'h0);
                chk("mid_clear_busy", 32'(rs_busy), 32'h0);
            end
            n++;
            tick();
        end
        chk("clr_busy_cycles", 32'(n), 32'd32);
        idle_inputs();
        for (int r = 0; r < 32; r += 2) begin
            rs_addr[0] = 5'(r);
            rs_addr[1] = 5'(r + 1);
            #1;
            chk($sformatf("post_clear_x%0d", r), rs_data[0], 32'h0);
            chk($sformatf("post_clear_x%0d", r + 1), rs_data[1], 32'h0);
        end
        rs_addr[0] = 5'd4;
        rs_addr[1] = 5'd6;
        #1;
        chk("post_clear_busy", 32'(rs_busy), 32'h0);
        tick();

        // Asynchronous reset in the middle of a sweep.
        rd_wren    = 2'b01;
        rd_addr[0] = 5'd20;
        rd_data[0] = 32'h55;
        alloc_en   = 1'b1;
        alloc_addr = 5'd8;
        tick();
        idle_inputs();
        rs_addr[0] = 5'd8;
        rs_addr[1] = 5'd20;
        #1;
        chk("pre_reset_busy_x8", 32'(rs_busy[0]), 32'h1);
        chk("pre_reset_x20", rs_data[1], 32'h55);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        chk("pre_reset_in_clear", 32'(clr_busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_clr_busy", 32'(clr_busy), 32'h0);
        chk("reset_mid_x20", rs_data[1], 32'h0);
        chk("reset_mid_busy", 32'(rs_busy), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (clr_busy && n < 100) begin
            n++;
            tick();
        end
        chk("reclear_cycles", 32'(n), 32'd32);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
